// File: rtl/adder_421_arb_pkg.sv
// Shared types and the round-robin pick helper for the 4:2:1 adder arbiter.
package adder_421_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);
  localparam int SUM_W       = 34;
  localparam int RR_MAX      = 32;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [SUM_W-1:0] sum;
  } rsp_t;

  // Lowest valid index strictly above ptr, else lowest valid index overall; -1 if none.
  function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr);
    logic [RR_MAX-1:0] above;
    logic [RR_MAX-1:0] masked;
    logic [RR_MAX-1:0] src;
    int                result;
    for (int i = 0; i < RR_MAX; i++) above[i] = (i > ptr);
    masked = valid & above;
    src    = (masked != '0) ? masked : valid;
    result = -1;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (src[i]) result = i;
    end
    return result;
  endfunction

endpackage

// File: rtl/arb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; data reads as zero when empty.
module arb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so push is allowed even when full.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/adder_421_arbiter.sv
// Round-robin sharing of one pipelined 4:2:1 adder; results return in issue order.
// Handshakes: a transfer happens on a cycle where valid & ready are both high; ready may depend on valid.
module adder_421_arbiter
  import adder_421_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IN_WIDTH    = 34,
  parameter int ADD_LATENCY = 4,
  parameter int RSP_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_c,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_d,
  output logic                        add_in_valid,
  output logic [IN_WIDTH-1:0]         add_a,
  output logic [IN_WIDTH-1:0]         add_b,
  output logic [IN_WIDTH-1:0]         add_c,
  output logic [IN_WIDTH-1:0]         add_d,
  input  logic [IN_WIDTH-1:0]         add_s,
  input  logic                        add_out_valid,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [IN_WIDTH-1:0]         rsp_sum,
  output logic                        err_unexpected
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int RSP_W = TAG_W + IN_WIDTH;

  logic [TAG_W-1:0]    last_grant;
  logic [OCC_W-1:0]    occ;
  int                  pick_idx;
  logic                has_req;
  logic                can_issue;
  logic                accept;
  logic                rsp_fire;
  logic [TAG_W-1:0]    grant_id;
  logic [IN_WIDTH-1:0] sel_a;
  logic [IN_WIDTH-1:0] sel_b;
  logic [IN_WIDTH-1:0] sel_c;
  logic [IN_WIDTH-1:0] sel_d;

  logic [TAG_W-1:0]    tag_head;
  logic [OCC_W-1:0]    tag_count;
  logic                tag_empty;
  logic                retire;
  logic [RSP_W-1:0]    rsp_word;
  logic [OCC_W-1:0]    rsp_count;

  assign pick_idx  = rr_pick(RR_MAX'(req_valid), 32'(last_grant));
  assign has_req   = (pick_idx >= 0);
  assign grant_id  = TAG_W'(pick_idx);
  // occ covers every issued-but-unconsumed request, so it also bounds both FIFOs.
  assign can_issue = (occ < OCC_W'(RSP_DEPTH));
  assign accept    = has_req && can_issue;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    sel_a = req_a[grant_id*IN_WIDTH +: IN_WIDTH];
    sel_b = req_b[grant_id*IN_WIDTH +: IN_WIDTH];
    sel_c = req_c[grant_id*IN_WIDTH +: IN_WIDTH];
    sel_d = req_d[grant_id*IN_WIDTH +: IN_WIDTH];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      add_in_valid   <= 1'b0;
      add_a          <= '0;
      add_b          <= '0;
      add_c          <= '0;
      add_d          <= '0;
      last_grant     <= TAG_W'(NUM_REQ - 1);
      occ            <= '0;
      err_unexpected <= 1'b0;
    end else begin
      add_in_valid <= accept;
      if (accept) begin
        add_a      <= sel_a;
        add_b      <= sel_b;
        add_c      <= sel_c;
        add_d      <= sel_d;
        last_grant <= grant_id;
      end
      if (accept && !rsp_fire)      occ <= occ + OCC_W'(1);
      else if (!accept && rsp_fire) occ <= occ - OCC_W'(1);
      if (add_out_valid && tag_empty) err_unexpected <= 1'b1;
    end
  end

  assign tag_empty = (tag_count == '0);
  assign retire    = add_out_valid && !tag_empty;

  arb_sync_fifo #(.WIDTH(TAG_W), .DEPTH(RSP_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_data (grant_id),
    .pop       (retire),
    .pop_data  (tag_head),
    .count     (tag_count)
  );

  arb_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (retire),
    .push_data ({tag_head, add_s}),
    .pop       (rsp_fire),
    .pop_data  (rsp_word),
    .count     (rsp_count)
  );

  assign rsp_valid = (rsp_count != '0);
  assign rsp_id    = rsp_word[RSP_W-1 -: TAG_W];
  assign rsp_sum   = rsp_word[IN_WIDTH-1:0];

endmodule

// File: tb/tb_adder_421_arbiter.sv
// Randomised and directed bench for adder_421_arbiter against a queue-based reference model.
module tb_adder_421_arbiter;
  import adder_421_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 34;
  localparam int L  = 4;
  localparam int D  = 8;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic           add_in_valid;
  logic [W-1:0]   add_a, add_b, add_c, add_d, add_s;
  logic           add_out_valid;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           err_unexpected;
  logic           force_spur = 1'b0;

  // Behavioural adder: sum of the four operands, L cycles after in_valid.
  logic [L-1:0] pipe_v;
  logic [W-1:0] pipe_s [L];
  assign add_out_valid = pipe_v[L-1] | force_spur;
  assign add_s         = pipe_s[L-1];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_v <= '0;
      for (int i = 0; i < L; i++) pipe_s[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[L-2:0], add_in_valid};
      pipe_s[0] <= add_a + add_b + add_c + add_d;
      for (int i = 1; i < L; i++) pipe_s[i] <= pipe_s[i-1];
    end
  end

  adder_421_arbiter #(.NUM_REQ(N), .IN_WIDTH(W), .ADD_LATENCY(L), .RSP_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .add_in_valid(add_in_valid), .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
    .add_s(add_s), .add_out_valid(add_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .err_unexpected(err_unexpected)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: queue of issued-but-unconsumed responses, each with the cycle it becomes visible.
  logic [$bits(rsp_t)-1:0] exp_q[$];
  int                      rdy_q[$];
  int                      cyc = 0;
  int                      m_last = N - 1;
  logic                    m_err = 1'b0;
  logic                    m_acc = 1'b0;
  logic [W-1:0]            m_a = '0, m_b = '0, m_c = '0, m_d = '0;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] g;
    g = '0;
    if (exp_q.size() >= D) return g;
    for (int j = 1; j <= N; j++) begin
      int idx;
      idx = (m_last + j) % N;
      if (req_valid[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic logic exp_valid();
    if (exp_q.size() == 0) return 1'b0;
    return rdy_q[0] <= cyc;
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      exp_q.delete();
      rdy_q.delete();
      m_last = N - 1;
      m_err  = 1'b0;
      m_acc  = 1'b0;
      m_a = '0; m_b = '0; m_c = '0; m_d = '0;
    end else begin
      logic [N-1:0] er;
      logic         pv;
      int           gi;
      er = exp_ready();
      pv = exp_valid();
      if (pv && rsp_ready) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      m_acc = |er;
      if (|er) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (er[i]) gi = i;
        m_a = req_a[gi*W +: W];
        m_b = req_b[gi*W +: W];
        m_c = req_c[gi*W +: W];
        m_d = req_d[gi*W +: W];
        exp_q.push_back({IW'(gi), W'(m_a + m_b + m_c + m_d)});
        // Accepted at edge cyc+1; one adder latency plus the response FIFO write later it is visible.
        rdy_q.push_back(cyc + L + 2);
        m_last = gi;
      end
      if (force_spur) m_err = 1'b1;
      cyc++;
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      logic [N-1:0] er;
      logic         ev;
      er = exp_ready();
      ev = exp_valid();
      check("req_ready", 64'(req_ready), 64'(er));
      check("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (ev) begin
        check("rsp_id", 64'(rsp_id), 64'(exp_q[0][W +: IW]));
        check("rsp_sum", 64'(rsp_sum), 64'(exp_q[0][W-1:0]));
      end
      check("add_in_valid", 64'(add_in_valid), 64'(m_acc));
      check("add_a", 64'(add_a), 64'(m_a));
      check("add_b", 64'(add_b), 64'(m_b));
      check("add_c", 64'(add_c), 64'(m_c));
      check("add_d", 64'(add_d), 64'(m_d));
      check("err_unexpected", 64'(err_unexpected), 64'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  logic [N-1:0] acc_v;

  task automatic tick();
    @(negedge clk);
    acc_v = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] r34();
    logic [31:0] hi;
    hi = $urandom_range(0, 3);
    return {hi[1:0], $urandom()};
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
    req_d[i*W +: W] = d;
  endtask

  task automatic rand_ops(input int i);
    set_ops(i, r34(), r34(), r34(), r34());
  endtask

  task automatic do_reset();
    req_valid  = '0;
    force_spur = 1'b0;
    resetn     = 1'b0;
    @(posedge clk);
    #1;
    check("rst req_ready", 64'(req_ready), 64'(0));
    check("rst add_in_valid", 64'(add_in_valid), 64'(0));
    check("rst add_a", 64'(add_a), 64'(0));
    check("rst add_d", 64'(add_d), 64'(0));
    check("rst rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst rsp_id", 64'(rsp_id), 64'(0));
    check("rst rsp_sum", 64'(rsp_sum), 64'(0));
    check("rst err", 64'(err_unexpected), 64'(0));
    check("rst occ", 64'(dut.occ), 64'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic drain(input int cycles);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (cycles) tick();
  endtask

  task automatic send_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
    int n;
    set_ops(id, a, b, c, d);
    req_valid[id] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_v[id] && n < 20);
    check("send accepted", 64'(acc_v[id]), 64'(1));
    req_valid[id] = 1'b0;
  endtask

  // Counts edges from the accepting edge until rsp_valid is seen, then consumes the response.
  task automatic wait_rsp(output logic [IW-1:0] id, output logic [W-1:0] s, output int edges);
    edges = 0;
    id = '0;
    s  = '0;
    while (edges < 50) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      #1;
      edges++;
    end
    check("rsp timeout", 64'(edges < 50), 64'(1));
    id = rsp_id;
    s  = rsp_sum;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [IW-1:0] gid;
    logic [W-1:0]  gsum;
    int            lat;
    int            acc_n;
    int            seq[$];

    // Single request from requester 2.
    do_reset();
    rsp_ready = 1'b1;
    send_one(2, 34'd1, 34'd2, 34'd3, 34'd4);
    wait_rsp(gid, gsum, lat);
    check("single id", 64'(gid), 64'(2));
    check("single sum", 64'(gsum), 64'(10));
    // rsp_valid appears in cycle k+2+L, i.e. L+1 edges after accepting edge k.
    check("single latency", 64'(lat), 64'(L + 1));
    drain(4);

    // Fairness with all requesters held valid.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) rand_ops(i);
    req_valid = '1;
    for (int t = 0; t < 12; t++) begin
      tick();
      check("fair one grant", 64'($countones(acc_v)), 64'(1));
      for (int i = 0; i < N; i++) if (acc_v[i]) begin
        seq.push_back(i);
        rand_ops(i);
      end
    end
    for (int j = 0; j < 8; j++) check("fair order", 64'(seq[j]), 64'(j % N));
    drain(12);

    // Backpressure: credit stops issue after D accepts.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) rand_ops(i);
    req_valid = '1;
    acc_n = 0;
    repeat (20) begin
      tick();
      acc_n += $countones(acc_v);
    end
    check("bp accepts", 64'(acc_n), 64'(D));
    check("bp req_ready", 64'(req_ready), 64'(0));
    rsp_ready = 1'b1;
    tick();
    acc_n += $countones(acc_v);
    rsp_ready = 1'b0;
    repeat (10) begin
      tick();
      acc_n += $countones(acc_v);
    end
    check("bp pulse accepts", 64'(acc_n), 64'(D + 1));
    drain(30);

    // Signed wrap-around.
    send_one(1, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFE, 34'd3, 34'd0);
    wait_rsp(gid, gsum, lat);
    check("wrap id", 64'(gid), 64'(1));
    check("wrap sum", 64'(gsum), 64'(0));
    send_one(3, 34'h1_FFFF_FFFF, 34'h1_FFFF_FFFF, 34'h1_FFFF_FFFF, 34'h1_FFFF_FFFF);
    wait_rsp(gid, gsum, lat);
    check("big id", 64'(gid), 64'(3));
    check("big sum", 64'(gsum), 64'h3_FFFF_FFFC);
    drain(4);

    // Random traffic with random backpressure; requesters hold valid and data until accepted.
    req_valid = '0;
    for (int t = 0; t < 600; t++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          rand_ops(i);
          req_valid[i] = 1'b1;
        end
      end
      tick();
      for (int i = 0; i < N; i++) if (acc_v[i]) req_valid[i] = 1'b0;
    end
    drain(30);
    check("random drained", 64'(exp_q.size()), 64'(0));

    // Reset with work in flight and buffered.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) rand_ops(i);
    req_valid = '1;
    repeat (7) tick();
    check("mid occ", 64'(dut.occ), 64'(7));
    do_reset();
    rsp_ready = 1'b1;
    repeat (10) begin
      tick();
      check("post-reset rsp_valid", 64'(rsp_valid), 64'(0));
    end
    req_valid = '1;
    tick();
    check("post-reset first grant", 64'(acc_v), 64'(4'b0001));
    drain(20);

    // Spurious adder result with nothing outstanding.
    check("idle before spur", 64'(exp_q.size()), 64'(0));
    force_spur = 1'b1;
    tick();
    force_spur = 1'b0;
    check("spur err", 64'(err_unexpected), 64'(1));
    check("spur rsp_valid", 64'(rsp_valid), 64'(0));
    check("spur occ", 64'(dut.occ), 64'(0));
    repeat (5) tick();
    check("spur err sticky", 64'(err_unexpected), 64'(1));
    check("spur rsp_valid later", 64'(rsp_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
